// File: rtl/alu_muldiv.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply, restoring divide, one step per cycle.
// Define ALU_MULDIV_DIV_EN to build the divider; without it DIV/DIVU pulse o_illegal.

module alu_muldiv #(
    parameter int unsigned IO_BUS_WIDTH  = 32,
    parameter int unsigned CTR_BUS_WIDTH = 3
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_valid,
    input  logic [CTR_BUS_WIDTH-1:0] i_ctr_code,
    input  logic [IO_BUS_WIDTH-1:0]  i_data_a,
    input  logic [IO_BUS_WIDTH-1:0]  i_data_b,
    input  logic                     i_flush,
    output logic                     o_ready,
    output logic                     o_done,
    output logic                     o_illegal,
    output logic [IO_BUS_WIDTH-1:0]  o_hi,
    output logic [IO_BUS_WIDTH-1:0]  o_lo
);

    localparam int unsigned N  = IO_BUS_WIDTH;
    localparam int unsigned CW = $clog2(N + 1);

    localparam logic [CTR_BUS_WIDTH-1:0] OP_MULT  = CTR_BUS_WIDTH'(1);
    localparam logic [CTR_BUS_WIDTH-1:0] OP_MULTU = CTR_BUS_WIDTH'(2);
    localparam logic [CTR_BUS_WIDTH-1:0] OP_DIV   = CTR_BUS_WIDTH'(3);
    localparam logic [CTR_BUS_WIDTH-1:0] OP_DIVU  = CTR_BUS_WIDTH'(4);
    localparam logic [CTR_BUS_WIDTH-1:0] OP_MTHI  = CTR_BUS_WIDTH'(5);
    localparam logic [CTR_BUS_WIDTH-1:0] OP_MTLO  = CTR_BUS_WIDTH'(6);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t          state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [N-1:0]    acc, acc_d;     // product high half / partial remainder
    logic [N-1:0]    shr, shr_d;     // multiplier / quotient shift register
    logic [N-1:0]    opd, opd_d;     // multiplicand / divisor magnitude
    logic            neg, neg_d;     // negate product or quotient in FIX
    logic [N-1:0]    hi_d, lo_d;
    logic            done_pend, done_pend_d;
    logic            illegal_d;
    logic            sgn_op;
    logic [N-1:0]    a_mag, b_mag;
    logic [N:0]      mul_sum;
    logic [2*N-1:0]  prod;
`ifdef ALU_MULDIV_DIV_EN
    logic            is_div, is_div_d;
    logic            neg_r, neg_r_d;
    logic            dz, dz_d;
    logic [N-1:0]    dvd, dvd_d;
    logic [N:0]      div_shift, div_diff;
`endif

    // Operand magnitudes at accept; only signed ops fold negative inputs
    assign sgn_op  = (i_ctr_code == OP_MULT) || (i_ctr_code == OP_DIV);
    assign a_mag   = (sgn_op && i_data_a[N-1]) ? (~i_data_a + N'(1)) : i_data_a;
    assign b_mag   = (sgn_op && i_data_b[N-1]) ? (~i_data_b + N'(1)) : i_data_b;

    assign mul_sum = {1'b0, acc} + {1'b0, opd};
    assign prod    = neg ? (~{acc, shr} + (2*N)'(1)) : {acc, shr};
`ifdef ALU_MULDIV_DIV_EN
    assign div_shift = {acc, shr[N-1]};
    assign div_diff  = div_shift - {1'b0, opd};
`endif

    // Next-state and datapath update
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        acc_d       = acc;
        shr_d       = shr;
        opd_d       = opd;
        neg_d       = neg;
        hi_d        = o_hi;
        lo_d        = o_lo;
        done_pend_d = 1'b0;
        illegal_d   = 1'b0;
`ifdef ALU_MULDIV_DIV_EN
        is_div_d    = is_div;
        neg_r_d     = neg_r;
        dz_d        = dz;
        dvd_d       = dvd;
`endif
        case (state)
            S_IDLE: begin
                if (i_valid) begin
                    case (i_ctr_code)
                        OP_MULT, OP_MULTU: begin
                            state_d = S_RUN;
                            cnt_d   = '0;
                            acc_d   = '0;
                            opd_d   = a_mag;
                            shr_d   = b_mag;
                            neg_d   = sgn_op && (i_data_a[N-1] ^ i_data_b[N-1]);
`ifdef ALU_MULDIV_DIV_EN
                            is_div_d = 1'b0;
`endif
                        end
                        OP_DIV, OP_DIVU: begin
`ifdef ALU_MULDIV_DIV_EN
                            state_d  = S_RUN;
                            cnt_d    = '0;
                            acc_d    = '0;
                            opd_d    = b_mag;
                            shr_d    = a_mag;
                            neg_d    = sgn_op && (i_data_a[N-1] ^ i_data_b[N-1]);
                            neg_r_d  = sgn_op && i_data_a[N-1];
                            dz_d     = (i_data_b == '0);
                            dvd_d    = i_data_a;
                            is_div_d = 1'b1;
`else
                            illegal_d = 1'b1;
`endif
                        end
                        OP_MTHI: hi_d = i_data_a;
                        OP_MTLO: lo_d = i_data_a;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (i_flush) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        state_d = S_FIX;
                    end
`ifdef ALU_MULDIV_DIV_EN
                    if (is_div) begin
                        if (!div_diff[N]) begin
                            acc_d = div_diff[N-1:0];
                            shr_d = {shr[N-2:0], 1'b1};
                        end else begin
                            acc_d = div_shift[N-1:0];
                            shr_d = {shr[N-2:0], 1'b0};
                        end
                    end else
`endif
                    if (shr[0]) begin
                        acc_d = mul_sum[N:1];
                        shr_d = {mul_sum[0], shr[N-1:1]};
                    end else begin
                        acc_d = {1'b0, acc[N-1:1]};
                        shr_d = {acc[0], shr[N-1:1]};
                    end
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!i_flush) begin
                    done_pend_d = 1'b1;
`ifdef ALU_MULDIV_DIV_EN
                    if (is_div) begin
                        if (dz) begin
                            lo_d = '1;
                            hi_d = dvd;
                        end else begin
                            lo_d = neg   ? (~shr + N'(1)) : shr;
                            hi_d = neg_r ? (~acc + N'(1)) : acc;
                        end
                    end else
`endif
                    begin
                        hi_d = prod[2*N-1:N];
                        lo_d = prod[N-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            acc       <= '0;
            shr       <= '0;
            opd       <= '0;
            neg       <= 1'b0;
            done_pend <= 1'b0;
            o_hi      <= '0;
            o_lo      <= '0;
            o_done    <= 1'b0;
            o_illegal <= 1'b0;
            o_ready   <= 1'b1;
`ifdef ALU_MULDIV_DIV_EN
            is_div    <= 1'b0;
            neg_r     <= 1'b0;
            dz        <= 1'b0;
            dvd       <= '0;
`endif
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            acc       <= acc_d;
            shr       <= shr_d;
            opd       <= opd_d;
            neg       <= neg_d;
            done_pend <= done_pend_d;
            o_hi      <= hi_d;
            o_lo      <= lo_d;
            o_done    <= done_pend;
            o_illegal <= illegal_d;
            o_ready   <= (state_d == S_IDLE);
`ifdef ALU_MULDIV_DIV_EN
            is_div    <= is_div_d;
            neg_r     <= neg_r_d;
            dz        <= dz_d;
            dvd       <= dvd_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv (N = 32); divide checks follow ALU_MULDIV_DIV_EN.

module tb_alu_muldiv;

    logic        clk;
    logic        rst_n_i;
    logic        valid;
    logic [2:0]  code;
    logic [31:0] da, db;
    logic        flush;
    logic        ready, done, illegal;
    logic [31:0] hi, lo;

    int checks   = 0;
    int failures = 0;

    alu_muldiv #(.IO_BUS_WIDTH(32), .CTR_BUS_WIDTH(3)) dut (
        .i_clk      (clk),
        .i_reset    (rst_n_i),
        .i_valid    (valid),
        .i_ctr_code (code),
        .i_data_a   (da),
        .i_data_b   (db),
        .i_flush    (flush),
        .o_ready    (ready),
        .o_done     (done),
        .o_illegal  (illegal),
        .o_hi       (hi),
        .o_lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        valid = 1'b1; code = c; da = a; db = b;
        tick();
        valid = 1'b0; code = 3'd0; da = 32'hDEADBEEF; db = 32'h0BADF00D;
    endtask

    // Edges after accept until o_done, or -1 if none within 60 cycles
    task automatic wait_done(output int edges);
        edges = -1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (done) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int e;
        rst_n_i = 1'b0; valid = 1'b1; code = 3'd5; da = 32'hFFFF0000; db = 32'h0; flush = 1'b1;
        tick(); tick();
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", ready); end
        checks++; if (done !== 1'b0 || illegal !== 1'b0) begin failures++; $display("FAIL reset_pulses: done %b illegal %b want 0 0", done, illegal); end
        checks++; if (hi !== 32'h0 || lo !== 32'h0) begin failures++; $display("FAIL reset_hilo: got %h %h want 0 0", hi, lo); end
        valid = 1'b0; flush = 1'b0; code = 3'd0; da = 32'h0;
        rst_n_i = 1'b1;
        tick();
        checks++; if (ready !== 1'b1 || hi !== 32'h0) begin failures++; $display("FAIL reset_release: ready %b hi %h want 1 0", ready, hi); end
        e = 0;
    endtask

    task automatic test_mult();
        logic [2:0]  tc [5] = '{3'd1, 3'd1, 3'd2, 3'd1, 3'd2};
        logic [31:0] ta [5] = '{32'd7, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF};
        logic [31:0] tb [5] = '{32'd6, 32'd5, 32'd5, 32'h80000000, 32'hFFFFFFFF};
        logic [31:0] eh [5] = '{32'h0, 32'hFFFFFFFF, 32'h00000004, 32'h40000000, 32'hFFFFFFFE};
        logic [31:0] el [5] = '{32'h2A, 32'hFFFFFFF1, 32'hFFFFFFF1, 32'h0, 32'h00000001};
        int e;
        for (int i = 0; i < 5; i++) begin
            start_op(tc[i], ta[i], tb[i]);
            checks++; if (ready !== 1'b0) begin failures++; $display("FAIL mult_busy[%0d]: ready %b want 0", i, ready); end
            wait_done(e);
            checks++; if (e !== 34) begin failures++; $display("FAIL mult_latency[%0d]: got %0d want 34", i, e); end
            checks++; if (hi !== eh[i]) begin failures++; $display("FAIL mult_hi[%0d]: got %h want %h", i, hi, eh[i]); end
            checks++; if (lo !== el[i]) begin failures++; $display("FAIL mult_lo[%0d]: got %h want %h", i, lo, el[i]); end
            tick();
            checks++; if (done !== 1'b0) begin failures++; $display("FAIL mult_pulse[%0d]: done %b want 0", i, done); end
        end
    endtask

`ifdef ALU_MULDIV_DIV_EN
    task automatic test_div();
        logic [2:0]  tc [6] = '{3'd3, 3'd4, 3'd3, 3'd3, 3'd4, 3'd3};
        logic [31:0] ta [6] = '{32'hFFFFFFF9, 32'd10, 32'h80000000, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFF9};
        logic [31:0] tb [6] = '{32'd2, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd16, 32'd0};
        logic [31:0] eh [6] = '{32'hFFFFFFFF, 32'h0000000A, 32'h0, 32'h1, 32'hF, 32'hFFFFFFF9};
        logic [31:0] el [6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFD, 32'h0FFFFFFF, 32'hFFFFFFFF};
        int e;
        for (int i = 0; i < 6; i++) begin
            start_op(tc[i], ta[i], tb[i]);
            wait_done(e);
            checks++; if (e !== 34) begin failures++; $display("FAIL div_latency[%0d]: got %0d want 34", i, e); end
            checks++; if (hi !== eh[i]) begin failures++; $display("FAIL div_hi[%0d]: got %h want %h", i, hi, eh[i]); end
            checks++; if (lo !== el[i]) begin failures++; $display("FAIL div_lo[%0d]: got %h want %h", i, lo, el[i]); end
        end
    endtask
`else
    task automatic test_illegal();
        int e;
        start_op(3'd5, 32'hA5A5A5A5, 32'h0);
        start_op(3'd6, 32'h5A5A5A5A, 32'h0);
        for (int k = 0; k < 2; k++) begin
            start_op(k == 0 ? 3'd3 : 3'd4, 32'd8, 32'd2);
            checks++; if (illegal !== 1'b1 || ready !== 1'b1) begin failures++; $display("FAIL illegal_pulse[%0d]: illegal %b ready %b want 1 1", k, illegal, ready); end
            tick();
            checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL illegal_width[%0d]: illegal %b want 0", k, illegal); end
            wait_done(e);
            checks++; if (e !== -1) begin failures++; $display("FAIL illegal_nodone[%0d]: done after %0d edges want none", k, e); end
            checks++; if (hi !== 32'hA5A5A5A5 || lo !== 32'h5A5A5A5A) begin failures++; $display("FAIL illegal_hilo[%0d]: got %h %h want a5a5a5a5 5a5a5a5a", k, hi, lo); end
        end
    endtask
`endif

    task automatic test_mtx();
        start_op(3'd5, 32'h12345678, 32'hFFFFFFFF);
        checks++; if (hi !== 32'h12345678 || done !== 1'b0 || ready !== 1'b1) begin failures++; $display("FAIL mthi: hi %h done %b ready %b want 12345678 0 1", hi, done, ready); end
        start_op(3'd6, 32'hCAFEF00D, 32'h0);
        checks++; if (lo !== 32'hCAFEF00D || hi !== 32'h12345678) begin failures++; $display("FAIL mtlo: lo %h hi %h want cafef00d 12345678", lo, hi); end
        start_op(3'd0, 32'h11111111, 32'h2);
        start_op(3'd7, 32'h22222222, 32'h3);
        tick();
        checks++; if (hi !== 32'h12345678 || lo !== 32'hCAFEF00D || done !== 1'b0 || illegal !== 1'b0) begin failures++; $display("FAIL nop: hi %h lo %h done %b illegal %b want 12345678 cafef00d 0 0", hi, lo, done, illegal); end
    endtask

    task automatic test_flush();
        int e;
        int d;
        start_op(3'd5, 32'h12345678, 32'h0);
        start_op(3'd6, 32'h9ABCDEF0, 32'h0);
        start_op(3'd1, 32'd3, 32'd3);
        d = 0;
        repeat (10) begin tick(); if (done) d++; end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL flush_run_ready: ready %b want 1", ready); end
        wait_done(e);
        checks++; if (e !== -1 || d !== 0) begin failures++; $display("FAIL flush_run_nodone: edges %0d early %0d want -1 0", e, d); end
        checks++; if (hi !== 32'h12345678 || lo !== 32'h9ABCDEF0) begin failures++; $display("FAIL flush_run_hilo: got %h %h want 12345678 9abcdef0", hi, lo); end
        // Flush while in FIX: N run edges after accept lands in FIX
        start_op(3'd1, 32'd9, 32'd9);
        repeat (32) tick();
        checks++; if (ready !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL flush_fix_pre: ready %b done %b want 0 0", ready, done); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL flush_fix_ready: ready %b want 1", ready); end
        wait_done(e);
        checks++; if (e !== -1 || hi !== 32'h12345678 || lo !== 32'h9ABCDEF0) begin failures++; $display("FAIL flush_fix: edges %0d hi %h lo %h want -1 12345678 9abcdef0", e, hi, lo); end
        // Flush alongside a request in IDLE: request proceeds
        flush = 1'b1;
        start_op(3'd1, 32'd4, 32'd5);
        flush = 1'b0;
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL flush_idle_accept: ready %b want 0", ready); end
        wait_done(e);
        checks++; if (e !== 34 || lo !== 32'd20 || hi !== 32'd0) begin failures++; $display("FAIL flush_idle_result: edges %0d hi %h lo %h want 34 0 14", e, hi, lo); end
    endtask

    task automatic test_back_to_back();
        int e;
        int d;
        valid = 1'b1; code = 3'd1; da = 32'd2; db = 32'd3;
        tick();
        da = 32'd100; db = 32'd100;
        d = 0;
        for (int i = 0; i < 60 && ready !== 1'b1; i++) begin
            tick();
            if (done) d++;
        end
        valid = 1'b0; code = 3'd0;
        checks++; if (d !== 0 || ready !== 1'b1) begin failures++; $display("FAIL b2b_hold: early done %0d ready %b want 0 1", d, ready); end
        tick();
        checks++; if (done !== 1'b1 || lo !== 32'd6 || hi !== 32'd0) begin failures++; $display("FAIL b2b_first: done %b hi %h lo %h want 1 0 6", done, hi, lo); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_in_done: ready %b want 1", ready); end
        start_op(3'd2, 32'h00010000, 32'h00010000);
        checks++; if (ready !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL b2b_accept: ready %b done %b want 0 0", ready, done); end
        wait_done(e);
        checks++; if (e !== 34 || hi !== 32'h1 || lo !== 32'h0) begin failures++; $display("FAIL b2b_second: edges %0d hi %h lo %h want 34 1 0", e, hi, lo); end
        wait_done(e);
        checks++; if (e !== -1) begin failures++; $display("FAIL b2b_extra_done: edges %0d want -1", e); end
    endtask

    task automatic test_reset_mid_run();
        int e;
        start_op(3'd5, 32'h77777777, 32'h0);
        start_op(3'd1, 32'd7, 32'd7);
        repeat (5) tick();
        rst_n_i = 1'b0; valid = 1'b1; code = 3'd6; da = 32'h55555555; flush = 1'b1;
        tick();
        rst_n_i = 1'b1; valid = 1'b0; code = 3'd0; flush = 1'b0;
        checks++; if (hi !== 32'h0 || lo !== 32'h0 || ready !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL reset_mid: hi %h lo %h ready %b done %b want 0 0 1 0", hi, lo, ready, done); end
        wait_done(e);
        checks++; if (e !== -1 || hi !== 32'h0 || lo !== 32'h0) begin failures++; $display("FAIL reset_mid_after: edges %0d hi %h lo %h want -1 0 0", e, hi, lo); end
    endtask

    initial begin
        valid = 1'b0; code = 3'd0; da = 32'h0; db = 32'h0; flush = 1'b0; rst_n_i = 1'b0;
        test_reset();
        test_mult();
`ifdef ALU_MULDIV_DIV_EN
        test_div();
`else
        test_illegal();
`endif
        test_mtx();
        test_flush();
        test_back_to_back();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
